// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and the
// baud divider calculation used by the transmitter (and later the receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned f, input int unsigned baud);
        return (f + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running modulo-DIV counter with synchronous clear.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   clr   - restart the count at 0 on the next edge
//   tick  - registered, high for the one cycle in which the count is DIV-1
module uart_baud_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(DIV);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_baud_gen: DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count; tick is registered so it lines up with cnt_q == DIV-1.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == CNT_W'(DIV - 1))) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == CNT_W'(DIV - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, framed as start bit,
// DATA_BITS data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   data  - word to transmit (latched on acceptance)
//   valid - producer has a word on data
//   ready - high in IDLE; handshake completes on valid && ready
//   tx    - serial line, idle high
//   busy  - frame in progress
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned F         = 50000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned DIV   = calc_div(F, BAUD);
    localparam int unsigned IDX_W = 4;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_frame: F/BAUD gives fewer than 2 clocks per bit");
        end
        if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_bits
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY > 2) begin : g_bad_par
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 clr_c;
    logic                 tick;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_c),
        .tick (tick)
    );

    // Next-state logic; outputs are derived from the next state so they
    // change on the same edge as the state register.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        clr_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (valid && ready_q) begin
                    state_d   = ST_START;
                    shift_d   = data;
                    par_d     = (PARITY == PAR_EVEN) ? ^data : ~^data;
                    bit_idx_d = '0;
                    clr_c     = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        bit_idx_d = '0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                // bit_idx counts stop bits here
                if (tick) begin
                    if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_d = 1'b1;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule
